// File: rtl/renode_ahb_subordinate_if.sv
// ============================================================================
//  Module   : renode_ahb_subordinate_if
//  Brief    : AHB-Lite subordinate port plus Renode bridge request/response port
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface renode_ahb_subordinate_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                      HSEL;
    logic [ADDR_WIDTH-1:0]     HADDR;
    logic [1:0]                HTRANS;
    logic                      HWRITE;
    logic [2:0]                HSIZE;
    logic [2:0]                HBURST;
    logic [DATA_WIDTH-1:0]     HWDATA;
    logic                      HREADY;
    logic                      HREADYOUT;
    logic                      HRESP;
    logic [DATA_WIDTH-1:0]     HRDATA;

    logic                      req_valid;
    logic                      req_ready;
    logic                      req_write;
    logic [ADDR_WIDTH-1:0]     req_addr;
    logic [DATA_WIDTH-1:0]     req_wdata;
    logic [DATA_WIDTH/8-1:0]   req_strb;
    logic                      rsp_valid;
    logic [DATA_WIDTH-1:0]     rsp_rdata;
    logic                      rsp_error;

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, HREADY,
        output HREADYOUT, HRESP, HRDATA,
        output req_valid, req_write, req_addr, req_wdata, req_strb,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error
    );

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, HREADY,
        input  HREADYOUT, HRESP, HRDATA,
        input  req_valid, req_write, req_addr, req_wdata, req_strb,
        output req_ready, rsp_valid, rsp_rdata, rsp_error
    );
endinterface

`default_nettype wire

// File: rtl/renode_ahb_subordinate.sv
// ============================================================================
//  Module   : renode_ahb_subordinate
//  Brief    : Terminates AHB-Lite transfers and turns each into one Renode
//             bridge request/response, with wait states and ERROR response.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module renode_ahb_subordinate #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  wire logic              HCLK,
    input  wire logic              HRESETn,
    renode_ahb_subordinate_if.slave bus
);
    localparam int         c_STRB_W = DATA_WIDTH / 8;
    localparam int         c_OFS_I  = $clog2(c_STRB_W);
    localparam logic [2:0] c_OFS    = 3'(c_OFS_I);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_RESP = 3'd3,
        S_ERR1 = 3'd4,
        S_ERR2 = 3'd5
    } state_t;

    state_t                  r_state;
    logic                    r_hreadyout;
    logic                    r_hresp;
    logic [DATA_WIDTH-1:0]   r_hrdata;
    logic                    r_req_valid;
    logic                    r_req_write;
    logic [ADDR_WIDTH-1:0]   r_req_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [c_STRB_W-1:0]     r_req_strb;

    logic                    w_accept;
    logic                    w_illegal;
    logic [7:0]              w_mask_full;
    logic [2:0]              w_align;
    logic [c_STRB_W-1:0]     w_strb;
    logic                    w_unused;

    assign w_accept = bus.HSEL & bus.HREADY & bus.HTRANS[1];

    always_comb begin
        w_mask_full = 8'hFF;
        w_align     = 3'b111;
        case (bus.HSIZE)
            3'd0:    begin w_mask_full = 8'h01; w_align = 3'b000; end
            3'd1:    begin w_mask_full = 8'h03; w_align = 3'b001; end
            3'd2:    begin w_mask_full = 8'h0F; w_align = 3'b011; end
            default: begin w_mask_full = 8'hFF; w_align = 3'b111; end
        endcase
    end

    // Lane mask shifted to the byte offset within the data bus (little-endian).
    assign w_strb    = w_mask_full[c_STRB_W-1:0] << bus.HADDR[c_OFS_I-1:0];
    assign w_illegal = (bus.HSIZE > c_OFS) || ((bus.HADDR[2:0] & w_align) != 3'b000);
    assign w_unused  = ^bus.HBURST;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state     <= S_IDLE;
            r_hreadyout <= 1'b1;
            r_hresp     <= 1'b0;
            r_hrdata    <= '0;
            r_req_valid <= 1'b0;
            r_req_write <= 1'b0;
            r_req_addr  <= '0;
            r_wdata     <= '0;
            r_req_strb  <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_RESP, S_ERR2: begin
                    if (w_accept && w_illegal) begin
                        r_state     <= S_ERR1;
                        r_hreadyout <= 1'b0;
                        r_hresp     <= 1'b1;
                    end else if (w_accept) begin
                        r_state     <= S_REQ;
                        r_hreadyout <= 1'b0;
                        r_hresp     <= 1'b0;
                        r_req_valid <= 1'b1;
                        r_req_write <= bus.HWRITE;
                        r_req_addr  <= bus.HADDR;
                        r_req_strb  <= w_strb;
                    end else begin
                        r_state     <= S_IDLE;
                        r_hreadyout <= 1'b1;
                        r_hresp     <= 1'b0;
                    end
                end
                S_REQ: begin
                    if (bus.req_ready) begin
                        r_state     <= S_WAIT;
                        r_req_valid <= 1'b0;
                        r_wdata     <= bus.HWDATA;
                    end
                end
                S_WAIT: begin
                    if (bus.rsp_valid && bus.rsp_error) begin
                        r_state <= S_ERR1;
                        r_hresp <= 1'b1;
                    end else if (bus.rsp_valid) begin
                        r_state     <= S_RESP;
                        r_hreadyout <= 1'b1;
                        if (!r_req_write) begin
                            r_hrdata <= bus.rsp_rdata;
                        end
                    end
                end
                S_ERR1: begin
                    r_state     <= S_ERR2;
                    r_hreadyout <= 1'b1;
                    r_hresp     <= 1'b1;
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_hreadyout <= 1'b1;
                    r_hresp     <= 1'b0;
                    r_req_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.HREADYOUT = r_hreadyout;
    assign bus.HRESP     = r_hresp;
    assign bus.HRDATA    = r_hrdata;
    assign bus.req_valid = r_req_valid;
    assign bus.req_write = r_req_write;
    assign bus.req_addr  = r_req_addr;
    assign bus.req_strb  = r_req_strb;
    // Write data tracks HWDATA while the request is offered, then holds the handshake value.
    assign bus.req_wdata = (r_state == S_REQ) ? bus.HWDATA : r_wdata;

endmodule

`default_nettype wire

// File: tb/tb_renode_ahb_subordinate.sv
// ============================================================================
//  Module   : tb_renode_ahb_subordinate
//  Brief    : Directed self-checking bench for renode_ahb_subordinate
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_renode_ahb_subordinate;
    logic HCLK    = 1'b0;
    logic HRESETn = 1'b1;
    int   n_total = 0;
    int   n_bad   = 0;

    renode_ahb_subordinate_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    renode_ahb_subordinate #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) u_dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (bus)
    );

    // Single subordinate on the bus: bus-level ready is our own ready.
    assign bus.HREADY = bus.HREADYOUT;

    always #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic smp();
        @(negedge HCLK);
    endtask

    task automatic addr_phase(input logic [31:0] a, input logic wr, input logic [2:0] sz);
        bus.HSEL   = 1'b1;
        bus.HTRANS = 2'd2;
        bus.HADDR  = a;
        bus.HWRITE = wr;
        bus.HSIZE  = sz;
    endtask

    task automatic bus_idle();
        bus.HSEL   = 1'b0;
        bus.HTRANS = 2'd0;
    endtask

    initial begin
        bus_idle();
        bus.HADDR     = '0;
        bus.HWRITE    = 1'b0;
        bus.HSIZE     = 3'd0;
        bus.HBURST    = 3'd0;
        bus.HWDATA    = '0;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.rsp_rdata = '0;
        bus.rsp_error = 1'b0;

        #2 HRESETn = 1'b0;
        #1;
        chk("rst_hreadyout", 64'(bus.HREADYOUT), 64'd1);
        chk("rst_hresp",     64'(bus.HRESP),     64'd0);
        chk("rst_hrdata",    64'(bus.HRDATA),    64'd0);
        chk("rst_req_valid", 64'(bus.req_valid), 64'd0);
        chk("rst_req_strb",  64'(bus.req_strb),  64'd0);
        chk("rst_req_addr",  64'(bus.req_addr),  64'd0);
        step();
        step();
        HRESETn = 1'b1;

        // Word read at 0x1000, response the cycle after the handshake
        addr_phase(32'h1000, 1'b0, 3'd2);
        bus.req_ready = 1'b1;
        smp(); chk("rd_idle_ready", 64'(bus.HREADYOUT), 64'd1);
        step(); bus_idle();
        smp();
        chk("rd_req_valid", 64'(bus.req_valid), 64'd1);
        chk("rd_req_write", 64'(bus.req_write), 64'd0);
        chk("rd_req_addr",  64'(bus.req_addr),  64'h1000);
        chk("rd_req_strb",  64'(bus.req_strb),  64'hF);
        chk("rd_ws1",       64'(bus.HREADYOUT), 64'd0);
        step();
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b1;
        bus.rsp_rdata = 32'hDEADBEEF;
        smp();
        chk("rd_ws2",       64'(bus.HREADYOUT), 64'd0);
        chk("rd_valid_off", 64'(bus.req_valid), 64'd0);
        step();
        bus.rsp_valid = 1'b0;
        smp();
        chk("rd_done_ready", 64'(bus.HREADYOUT), 64'd1);
        chk("rd_done_resp",  64'(bus.HRESP),     64'd0);
        chk("rd_hrdata",     64'(bus.HRDATA),    64'hDEADBEEF);
        step();

        // Byte write 0xAB at 0x2003 with req_ready held off for 3 cycles
        addr_phase(32'h2003, 1'b1, 3'd0);
        step(); bus_idle();
        bus.HWDATA = 32'hAB000000;
        for (int k = 0; k < 3; k++) begin
            smp();
            chk("wr_valid_hold", 64'(bus.req_valid), 64'd1);
            chk("wr_strb",       64'(bus.req_strb),  64'h8);
            chk("wr_wdata",      64'(bus.req_wdata), 64'hAB000000);
            chk("wr_addr",       64'(bus.req_addr),  64'h2003);
            chk("wr_write",      64'(bus.req_write), 64'd1);
            chk("wr_stall",      64'(bus.HREADYOUT), 64'd0);
            step();
        end
        bus.req_ready = 1'b1;
        smp(); chk("wr_valid_hs", 64'(bus.req_valid), 64'd1);
        chk("wr_stall4", 64'(bus.HREADYOUT), 64'd0);
        step();
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b1;
        bus.rsp_rdata = 32'h12345678;
        smp();
        chk("wr_stall5",      64'(bus.HREADYOUT), 64'd0);
        chk("wr_valid_off",   64'(bus.req_valid), 64'd0);
        chk("wr_wdata_held",  64'(bus.req_wdata), 64'hAB000000);
        step();
        bus.rsp_valid = 1'b0;
        smp();
        chk("wr_done_ready", 64'(bus.HREADYOUT), 64'd1);
        chk("wr_hrdata_kept", 64'(bus.HRDATA),   64'hDEADBEEF);
        step();

        // Misaligned halfword write at 0x3001 -> ERROR without a request
        addr_phase(32'h3001, 1'b1, 3'd1);
        step(); bus_idle();
        smp();
        chk("ill_no_req", 64'(bus.req_valid), 64'd0);
        chk("ill_e1_resp", 64'(bus.HRESP),     64'd1);
        chk("ill_e1_rdy",  64'(bus.HREADYOUT), 64'd0);
        step();
        smp();
        chk("ill_e2_resp", 64'(bus.HRESP),     64'd1);
        chk("ill_e2_rdy",  64'(bus.HREADYOUT), 64'd1);
        chk("ill_e2_noreq", 64'(bus.req_valid), 64'd0);
        step();
        smp();
        chk("ill_after_resp", 64'(bus.HRESP), 64'd0);

        // Read at 0x4000 answered with rsp_error
        step();
        addr_phase(32'h4000, 1'b0, 3'd2);
        bus.req_ready = 1'b1;
        step(); bus_idle();
        step();
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b1;
        bus.rsp_error = 1'b1;
        bus.rsp_rdata = 32'h55555555;
        smp(); chk("be_wait_resp", 64'(bus.HRESP), 64'd0);
        step();
        bus.rsp_valid = 1'b0;
        bus.rsp_error = 1'b0;
        bus.HSEL      = 1'b1;
        bus.HTRANS    = 2'd0;
        smp();
        chk("be_e1_resp", 64'(bus.HRESP),     64'd1);
        chk("be_e1_rdy",  64'(bus.HREADYOUT), 64'd0);
        step();
        smp();
        chk("be_e2_resp", 64'(bus.HRESP),     64'd1);
        chk("be_e2_rdy",  64'(bus.HREADYOUT), 64'd1);
        step();
        smp();
        chk("be_idle_resp", 64'(bus.HRESP),     64'd0);
        chk("be_idle_rdy",  64'(bus.HREADYOUT), 64'd1);
        chk("be_idle_noreq", 64'(bus.req_valid), 64'd0);
        chk("be_hrdata_kept", 64'(bus.HRDATA),  64'hDEADBEEF);
        step(); bus_idle();

        // Back-to-back reads at 0x10 and 0x14, second address phase in RESP
        addr_phase(32'h10, 1'b0, 3'd2);
        bus.req_ready = 1'b1;
        step(); bus_idle();
        smp(); chk("b2b_addr0", 64'(bus.req_addr), 64'h10);
        step();
        bus.rsp_valid = 1'b1;
        bus.rsp_rdata = 32'h11111111;
        step();
        bus.rsp_valid = 1'b0;
        addr_phase(32'h14, 1'b0, 3'd2);
        smp();
        chk("b2b_resp_rdy", 64'(bus.HREADYOUT), 64'd1);
        chk("b2b_hrdata0",  64'(bus.HRDATA),    64'h11111111);
        step(); bus_idle();
        smp();
        chk("b2b_valid1", 64'(bus.req_valid), 64'd1);
        chk("b2b_addr1",  64'(bus.req_addr),  64'h14);
        chk("b2b_stall1", 64'(bus.HREADYOUT), 64'd0);
        step();
        bus.rsp_valid = 1'b1;
        bus.rsp_rdata = 32'h22222222;
        step();
        bus.rsp_valid = 1'b0;
        bus.req_ready = 1'b0;
        smp();
        chk("b2b_hrdata1", 64'(bus.HRDATA),    64'h22222222);
        chk("b2b_rdy1",    64'(bus.HREADYOUT), 64'd1);
        step();

        // Reset asserted while waiting for the bridge response
        addr_phase(32'h5000, 1'b0, 3'd2);
        bus.req_ready = 1'b1;
        step(); bus_idle();
        step();
        bus.req_ready = 1'b0;
        smp(); chk("rw_wait_stall", 64'(bus.HREADYOUT), 64'd0);
        #1 HRESETn = 1'b0;
        #1;
        chk("rw_async_rdy",   64'(bus.HREADYOUT), 64'd1);
        chk("rw_async_valid", 64'(bus.req_valid), 64'd0);
        chk("rw_async_rdata", 64'(bus.HRDATA),    64'd0);
        chk("rw_async_addr",  64'(bus.req_addr),  64'd0);
        step();
        HRESETn = 1'b1;
        bus.rsp_valid = 1'b1;
        bus.rsp_rdata = 32'h99999999;
        smp();
        chk("rw_stray_rdy", 64'(bus.HREADYOUT), 64'd1);
        step();
        bus.rsp_valid = 1'b0;
        smp();
        chk("rw_stray_rdata", 64'(bus.HRDATA),    64'd0);
        chk("rw_stray_rdy2",  64'(bus.HREADYOUT), 64'd1);
        chk("rw_stray_resp",  64'(bus.HRESP),     64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/renode_ahb_subordinate.md
# renode_ahb_subordinate

AHB-Lite subordinate endpoint that terminates transfers issued by an RTL manager under co-simulation and converts each into a single-beat request/response exchange toward the Renode bus connection bridge. It sits between the DUT manager (via `renode_ahb_if`) and the Renode-side transaction port. It also inserts wait states until the response arrives, generates byte strobes, and produces the two-cycle AHB ERROR response.

## Interface
- ADDR_WIDTH, 32, HADDR / req_addr width
- DATA_WIDTH, 32, HWDATA/HRDATA width; 32 or 64 only
- HCLK  in  1  bus clock; all logic on rising edge
- HRESETn  in  1  asynchronous, active-low reset
- HSEL  in  1  subordinate select
- HADDR  in  ADDR_WIDTH  transfer address
- HTRANS  in  2  0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ
- HWRITE  in  1  1 = write
- HSIZE  in  3  log2(bytes)
- HBURST  in  3  ignored; every beat handled as a single transfer
- HWDATA  in  DATA_WIDTH  write data, valid in data phase
- HREADY  in  1  bus-level ready (qualifies address phase)
- HREADYOUT  out  1  subordinate ready
- HRESP  out  1  0 OKAY, 1 ERROR
- HRDATA  out  DATA_WIDTH  read data
- req_valid  out  1  request to bridge
- req_ready  in  1  bridge accepts request
- req_write  out  1  request direction
- req_addr  out  ADDR_WIDTH  captured HADDR
- req_wdata  out  DATA_WIDTH  write data
- req_strb  out  DATA_WIDTH/8  byte-lane enables
- rsp_valid  in  1  bridge response strobe (single cycle)
- rsp_rdata  in  DATA_WIDTH  read data
- rsp_error  in  1  bridge reports error

## Operation
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, req_valid=0, req_write=0, req_addr=0, req_wdata=0, req_strb=0; state IDLE.
- Transfer accepted at a rising edge when HSEL & HREADY & HTRANS[1]; HADDR, HWRITE, HSIZE captured. IDLE/BUSY, or HSEL low: no request, OKAY, zero wait.
- Strobe: bytes = 1<<HSIZE; req_strb = ((1<<bytes)-1) << HADDR[OFS-1:0], OFS = log2(DATA_WIDTH/8); little-endian lanes.
- Illegal transfer (HSIZE > OFS, or HADDR not aligned to bytes): no request issued; goes directly to ERR1.
- States: IDLE -> REQ (legal accept) | ERR1 (illegal accept); REQ -> WAIT on req_valid & req_ready; WAIT -> RESP on rsp_valid & !rsp_error, ERR1 on rsp_valid & rsp_error; ERR1 -> ERR2; ERR2 -> IDLE/REQ/ERR1 by the accept rule; RESP -> IDLE/REQ/ERR1 by the accept rule.
- REQ: req_valid=1, HREADYOUT=0. req_wdata driven from HWDATA (stable while stalled), register the value on handshake. req_valid held until req_ready; fields stable while held.
- WAIT: HREADYOUT=0, HRESP=0; rsp_valid sampled only here; rsp_valid in other states is ignored.
- RESP: HREADYOUT=1, HRESP=0. HRDATA = rsp_rdata registered on the response edge for reads; unchanged for writes.
- ERR1: HRESP=1, HREADYOUT=0. ERR2: HRESP=1, HREADYOUT=1. HRDATA unchanged.
- Next address phase accepted during RESP/ERR2 (pipelined back-to-back); in ERR2 the manager may instead drive IDLE.
- Exactly one outstanding request; no buffering.

## Timing
- Address phase in cycle A. Earliest request: REQ in A+1.
- Minimum read/write latency (req_ready=1 in A+1, rsp_valid in A+2): HREADYOUT low in A+1 and A+2, high in A+3. That is 2 wait states.
- Every extra cycle of req_ready=0 or missing rsp_valid adds one wait state. There is no timeout.
- Illegal transfer: ERR1 in A+1, ERR2 in A+2. No req_valid.
- HRESETn low: all outputs return to their reset values asynchronously and the state returns to IDLE. An in-flight request is dropped, and the bridge must be reset with it.
- Reset release: first accept possible at the first rising edge with HRESETn high.

## Test plan
- Read of word at 0x1000, size 2, bridge replies rsp_rdata=0xDEADBEEF the next cycle -> req_strb=0xF, HREADYOUT low 2 cycles, then high with HRDATA=0xDEADBEEF, HRESP=0.
- Byte write 0xAB at 0x2003 (HWDATA=0xAB000000) with req_ready delayed 3 cycles -> req_strb=0x8, req_wdata=0xAB000000, fields stable throughout, 5 wait states.
- Halfword write at 0x3001 -> no req_valid, HRESP=1 with HREADYOUT=0 then HRESP=1 with HREADYOUT=1.
- Read at 0x4000 with rsp_error=1 -> two-cycle ERROR response; the following IDLE transfer gets OKAY with zero wait.
- Back-to-back NONSEQ reads at 0x10 and 0x14, second address phase during RESP -> second req_valid in the cycle after RESP, no lost transfer.
- HRESETn asserted while in WAIT -> HREADYOUT=1, req_valid=0 immediately; a later stray rsp_valid is ignored.
